// File: rtl/br_flow_xbar_wrr_pkg.sv
// Index helpers for the weighted round-robin flow crossbar.
// Each consumer keeps its own widths as local parameters.
package br_flow_xbar_wrr_pkg;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic int circ_idx(input int start, input int offset, input int n);
        return (start + offset) % n;
    endfunction

endpackage

// File: rtl/br_arb_wrr.sv
// Weighted round-robin arbiter: the holder keeps priority until it has used
// its weight in credits, then the search starts just past it.
module br_arb_wrr
    import br_flow_xbar_wrr_pkg::*;
#(
    parameter int NumRequesters = 2,
    parameter int MaxWeight = 4,
    localparam int WeightWidth = $clog2(MaxWeight + 1),
    localparam int IdWidth = $clog2(NumRequesters)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NumRequesters-1:0]                request,
    input  logic [NumRequesters-1:0][WeightWidth-1:0] weight,
    input  logic                                    enable_priority_update,
    output logic [NumRequesters-1:0]                grant,
    output logic [IdWidth-1:0]                      grant_id
);

    logic [IdWidth-1:0]     holder;
    logic [WeightWidth-1:0] used;
    logic [WeightWidth-1:0] hold_w;
    logic                   found;
    int                     start;
    int                     idx;

    always_comb begin
        hold_w   = (weight[holder] == '0) ? WeightWidth'(1) : weight[holder];
        start    = (used < hold_w) ? int'(holder) : wrap_inc(int'(holder), NumRequesters);
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NumRequesters; k++) begin
            idx = circ_idx(start, k, NumRequesters);
            if (!found && request[IdWidth'(idx)]) begin
                grant[IdWidth'(idx)] = 1'b1;
                grant_id             = IdWidth'(idx);
                found                = 1'b1;
            end
        end
    end

    // Reset leaves credit exhausted on the last flow so flow 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            holder <= IdWidth'(NumRequesters - 1);
            used   <= WeightWidth'(MaxWeight);
        end else if (enable_priority_update && found) begin
            if (grant_id == holder) begin
                if (used < WeightWidth'(MaxWeight)) used <= used + WeightWidth'(1);
            end else begin
                holder <= grant_id;
                used   <= WeightWidth'(1);
            end
        end
    end

endmodule

// File: rtl/br_flow_xbar_wrr.sv
// Flow crossbar with one weighted round-robin arbiter per output and an
// optional one-entry forward register in front of each pop port.
module br_flow_xbar_wrr
    import br_flow_xbar_wrr_pkg::*;
#(
    parameter int NumPushFlows = 2,
    parameter int NumPopFlows = 2,
    parameter int Width = 1,
    parameter int MaxWeight = 4,
    parameter bit RegisterPopOutputs = 1'b0,
    localparam int WeightWidth = $clog2(MaxWeight + 1),
    localparam int SrcWidth = $clog2(NumPushFlows),
    localparam int DestWidth = $clog2(NumPopFlows)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NumPushFlows-1:0][WeightWidth-1:0] config_weight,
    output logic [NumPushFlows-1:0]                  push_ready,
    input  logic [NumPushFlows-1:0]                  push_valid,
    input  logic [NumPushFlows-1:0][Width-1:0]       push_data,
    input  logic [NumPushFlows-1:0][DestWidth-1:0]   push_dest_id,
    input  logic [NumPopFlows-1:0]                   pop_ready,
    output logic [NumPopFlows-1:0]                   pop_valid,
    output logic [NumPopFlows-1:0][Width-1:0]        pop_data,
    output logic [NumPopFlows-1:0][SrcWidth-1:0]     pop_src_id
);

    logic [NumPopFlows-1:0][NumPushFlows-1:0] request;
    logic [NumPopFlows-1:0][NumPushFlows-1:0] grant;
    logic [NumPopFlows-1:0][SrcWidth-1:0]     grant_id;
    logic [NumPopFlows-1:0]                   enable_priority_update;
    logic [NumPopFlows-1:0]                   stage_ready;

    for (genvar i = 0; i < NumPushFlows; i++) begin : g_push
        a_dest_legal: assert property (@(posedge clk) disable iff (rst)
            push_valid[i] |-> (32'(push_dest_id[i]) < NumPopFlows));
    end

    for (genvar p = 0; p < NumPopFlows; p++) begin : g_pop
        logic             arb_valid;
        logic [Width-1:0] arb_data;

        for (genvar i = 0; i < NumPushFlows; i++) begin : g_req
            assign request[p][i] = push_valid[i] & (push_dest_id[i] == DestWidth'(p));
        end

        br_arb_wrr #(
            .NumRequesters(NumPushFlows),
            .MaxWeight    (MaxWeight)
        ) u_arb (
            .clk                   (clk),
            .rst                   (rst),
            .request               (request[p]),
            .weight                (config_weight),
            .enable_priority_update(enable_priority_update[p]),
            .grant                 (grant[p]),
            .grant_id              (grant_id[p])
        );

        // Grant is one-hot or zero, so an OR-mux is enough.
        always_comb begin
            arb_data = '0;
            for (int i = 0; i < NumPushFlows; i++) begin
                if (grant[p][i]) arb_data = arb_data | push_data[i];
            end
        end

        assign arb_valid                 = (|grant[p]) & ~rst;
        assign enable_priority_update[p] = arb_valid & stage_ready[p];

        if (RegisterPopOutputs) begin : g_reg
            logic                full;
            logic [Width-1:0]    data_q;
            logic [SrcWidth-1:0] src_q;

            assign stage_ready[p] = ~full | pop_ready[p];

            always_ff @(posedge clk) begin
                if (rst) begin
                    full <= 1'b0;
                end else if (stage_ready[p]) begin
                    full <= arb_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (stage_ready[p] && arb_valid) begin
                    data_q <= arb_data;
                    src_q  <= grant_id[p];
                end
            end

            assign pop_valid[p]  = full;
            assign pop_data[p]   = data_q;
            assign pop_src_id[p] = src_q;
        end else begin : g_comb
            assign stage_ready[p] = pop_ready[p];
            assign pop_valid[p]   = arb_valid;
            assign pop_data[p]    = arb_data;
            assign pop_src_id[p]  = grant_id[p];
        end
    end

    always_comb begin
        push_ready = '0;
        for (int p = 0; p < NumPopFlows; p++) begin
            push_ready = push_ready | (grant[p] & {NumPushFlows{stage_ready[p]}});
        end
        if (rst) push_ready = '0;
    end

endmodule

// File: tb/tb_br_flow_xbar_wrr.sv
// Bench for br_flow_xbar_wrr: a combinational-output and a registered-output
// instance, each checked cycle by cycle against a credit-counting model.
module tb_br_flow_xbar_wrr;

    localparam int NP = 3;
    localparam int NQ = 2;
    localparam int W  = 8;
    localparam int MW = 4;
    localparam int WW = 3;
    localparam int SW = 2;
    localparam int DW = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NP-1:0][WW-1:0] cw;

    logic [NP-1:0]         pv   [2];
    logic [NP-1:0][W-1:0]  pd   [2];
    logic [NP-1:0][DW-1:0] pdst [2];
    logic [NQ-1:0]         prdy [2];
    logic [NP-1:0]         pr   [2];
    logic [NQ-1:0]         ov   [2];
    logic [NQ-1:0][W-1:0]  od   [2];
    logic [NQ-1:0][SW-1:0] os   [2];

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: holder and used credit per output, plus the forward register.
    int mh    [2][NQ];
    int mc    [2][NQ];
    bit mfull [2][NQ];
    int mdata [2][NQ];
    int msrc  [2][NQ];
    bit mpr   [2][NP];

    always #5 clk = ~clk;

    br_flow_xbar_wrr #(.NumPushFlows(NP), .NumPopFlows(NQ), .Width(W), .MaxWeight(MW),
                       .RegisterPopOutputs(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .config_weight(cw), .push_ready(pr[0]),
        .push_valid(pv[0]), .push_data(pd[0]), .push_dest_id(pdst[0]),
        .pop_ready(prdy[0]), .pop_valid(ov[0]), .pop_data(od[0]), .pop_src_id(os[0]));

    br_flow_xbar_wrr #(.NumPushFlows(NP), .NumPopFlows(NQ), .Width(W), .MaxWeight(MW),
                       .RegisterPopOutputs(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .config_weight(cw), .push_ready(pr[1]),
        .push_valid(pv[1]), .push_data(pd[1]), .push_dest_id(pdst[1]),
        .pop_ready(prdy[1]), .pop_valid(ov[1]), .pop_data(od[1]), .pop_src_id(os[1]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int effw(input int i);
        return (cw[i] == 0) ? 1 : int'(cw[i]);
    endfunction

    task automatic model_cycle(input int d);
        int g[NQ];
        bit sr[NQ];
        int st, dst, i;
        if (rst) begin
            for (int k = 0; k < NP; k++) chk("rst_push_ready", 32'(pr[d][k]), 0);
            for (int p = 0; p < NQ; p++) begin
                chk("rst_pop_valid", 32'(ov[d][p]), (d == 1) ? 32'(mfull[d][p]) : 0);
                mh[d][p] = NP - 1;
                mc[d][p] = MW;
                mfull[d][p] = 1'b0;
            end
            for (int k = 0; k < NP; k++) mpr[d][k] = 1'b0;
            return;
        end
        for (int p = 0; p < NQ; p++) begin
            g[p] = -1;
            st = (mc[d][p] < effw(mh[d][p])) ? mh[d][p] : (mh[d][p] + 1) % NP;
            for (int k = 0; k < NP; k++) begin
                i = (st + k) % NP;
                if (g[p] < 0 && pv[d][i] && int'(pdst[d][i]) == p) g[p] = i;
            end
            sr[p] = (d == 1) ? (!mfull[d][p] || prdy[d][p]) : prdy[d][p];
        end
        for (int k = 0; k < NP; k++) begin
            dst = int'(pdst[d][k]);
            mpr[d][k] = pv[d][k] && g[dst] == k && sr[dst];
            chk("push_ready", 32'(pr[d][k]), 32'(mpr[d][k]));
        end
        for (int p = 0; p < NQ; p++) begin
            if (d == 0) begin
                chk("pop_valid", 32'(ov[d][p]), 32'(g[p] >= 0));
                if (g[p] >= 0) begin
                    chk("pop_data", 32'(od[d][p]), 32'(pd[d][g[p]]));
                    chk("pop_src_id", 32'(os[d][p]), g[p]);
                end
            end else begin
                chk("reg_pop_valid", 32'(ov[d][p]), 32'(mfull[d][p]));
                if (mfull[d][p]) begin
                    chk("reg_pop_data", 32'(od[d][p]), mdata[d][p]);
                    chk("reg_pop_src_id", 32'(os[d][p]), msrc[d][p]);
                end
            end
            if (g[p] >= 0 && sr[p]) begin
                if (g[p] == mh[d][p]) mc[d][p] = (mc[d][p] < MW) ? mc[d][p] + 1 : MW;
                else begin
                    mh[d][p] = g[p];
                    mc[d][p] = 1;
                end
            end
            if (d == 1 && sr[p]) begin
                mfull[d][p] = (g[p] >= 0);
                if (g[p] >= 0) begin
                    mdata[d][p] = int'(pd[d][g[p]]);
                    msrc[d][p]  = g[p];
                end
            end
        end
    endtask

    // exp_src0 >= 0 also checks dut0's pop 0 against a fixed expected source.
    task automatic cycle(input int exp_src0);
        #1;
        if (exp_src0 >= 0) begin
            chk("seq_valid", 32'(ov[0][0]), 1);
            chk("seq_src", 32'(os[0][0]), exp_src0);
        end
        for (int d = 0; d < 2; d++) model_cycle(d);
        @(negedge clk);
    endtask

    task automatic set_all(input logic [NP-1:0] v, input logic [NQ-1:0] r);
        for (int d = 0; d < 2; d++) begin
            pv[d]   = v;
            prdy[d] = r;
            for (int i = 0; i < NP; i++) begin
                pd[d][i]   = 8'(16 * (i + 1) + 1);
                pdst[d][i] = '0;
            end
        end
    endtask

    task automatic rand_inputs(input int d);
        for (int i = 0; i < NP; i++) begin
            if (!(pv[d][i] && !mpr[d][i])) begin
                pv[d][i]   = ($urandom_range(99) < 70);
                pd[d][i]   = 8'($urandom);
                pdst[d][i] = 1'($urandom_range(1));
            end
        end
        for (int p = 0; p < NQ; p++) prdy[d][p] = ($urandom_range(99) < 75);
    endtask

    initial begin
        int s1[6]  = '{0, 1, 2, 0, 1, 2};
        int s2[10] = '{0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
        rst = 1'b1;
        cw  = {3'd1, 3'd1, 3'd1};
        set_all('0, '0);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NQ; p++) begin
                mh[d][p] = NP - 1; mc[d][p] = MW; mfull[d][p] = 1'b0;
                mdata[d][p] = 0; msrc[d][p] = 0;
            end
            for (int i = 0; i < NP; i++) mpr[d][i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        cycle(-1);
        rst = 1'b0;

        // Equal weights: plain rotation.
        set_all(3'b111, 2'b11);
        for (int k = 0; k < 6; k++) cycle(s1[k]);

        // Weights {3,1,0}: zero weight acts as one.
        set_all('0, 2'b11);
        cw = {3'd0, 3'd1, 3'd3};
        cycle(-1);
        set_all(3'b111, 2'b11);
        for (int k = 0; k < 10; k++) cycle(s2[k]);

        // Holder drops out mid-burst, then returns.
        set_all('0, 2'b11);
        cw = {3'd1, 3'd1, 3'd3};
        cycle(-1);
        set_all(3'b011, 2'b11); cycle(0);
        set_all(3'b010, 2'b11); cycle(1);
        set_all(3'b011, 2'b11); cycle(0);

        // Backpressure on pop 0 holds the grant.
        set_all(3'b111, 2'b10);
        repeat (5) cycle(0);
        set_all(3'b111, 2'b11);
        cycle(0); cycle(0); cycle(1);

        // Reset with holder 0 on its last credit: flow 0 still goes first after.
        set_all('0, 2'b11);
        cw = {3'd1, 3'd1, 3'd2};
        cycle(-1);
        set_all(3'b001, 2'b11); cycle(0); cycle(0);
        rst = 1'b1;
        set_all(3'b111, 2'b11); cycle(-1);
        rst = 1'b0;
        cycle(0);

        // Random traffic with occasional weight changes and resets.
        for (int k = 0; k < 2000; k++) begin
            rst = ($urandom_range(299) == 0);
            if (k % 64 == 0) begin
                set_all('0, 2'b11);
                for (int i = 0; i < NP; i++) cw[i] = 3'($urandom_range(MW));
            end else begin
                for (int d = 0; d < 2; d++) rand_inputs(d);
            end
            cycle(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
